alu_seq_pipe: RTL and testbench

- Parametrised, handshaked successor to the generated combinational ALUs.
- Same 9-op opcode map, plus:
  - registered output with valid/ready flow control on both sides;
  - multi-cycle iterative unsigned divider, which replaces the combinational divide;
  - zero, divide-by-zero and illegal-opcode flags;
  - a pass-through transaction tag.
- Sits between an issue stage and a writeback/consumer stage.

---
 rtl/alu_seq_pipe.sv | 201 ++++++++++++++++++++
 tb/tb_alu_seq_pipe.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_pipe.sv
// alu_seq_pipe: valid/ready ALU with a registered result stage
// and an iterative restoring divider for non-zero divisors.
module alu_seq_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int SHIFT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   input1,
  input  logic [WIDTH-1:0]   input2,
  input  logic [SHIFT_W-1:0] shiftValue,
  input  logic [TAG_W-1:0]   inTag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               carryFlag,
  output logic               zeroFlag,
  output logic               divZeroFlag,
  output logic               illegalOpFlag,
  output logic [TAG_W-1:0]   outTag
);

  localparam int CW = SHIFT_W + 1;

  localparam logic [3:0] OP_ROL = 4'd0;
  localparam logic [3:0] OP_ROR = 4'd1;
  localparam logic [3:0] OP_MAX = 4'd2;
  localparam logic [3:0] OP_MIN = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_DIV = 4'd6;
  localparam logic [3:0] OP_NOR = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8;

  typedef enum logic {IDLE, DIV_RUN} state_e;

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               dz_q, dz_d;
  logic               ill_q, ill_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [TAG_W-1:0]   dtag_q, dtag_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               fire;
  logic               div_long;
  logic [SHIFT_W-1:0] neg_s;
  logic [WIDTH:0]     sum_w, dif_w;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_carry, sc_dz, sc_ill;
  logic [WIDTH:0]     trial, trial_sub;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_n, quo_n;

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign fire     = in_valid && in_ready;
  assign div_long = (opcode == OP_DIV) && (input2 != '0);

  // Rotate as two shifts; -s mod WIDTH keeps s=0 free of a WIDTH shift.
  always_comb begin
    neg_s    = '0 - shiftValue;
    sum_w    = {1'b0, input1} + {1'b0, input2};
    dif_w    = {1'b0, input1} - {1'b0, input2};
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_dz    = 1'b0;
    sc_ill   = 1'b0;
    case (opcode)
      OP_ROL: sc_res = (input1 << shiftValue) | (input1 >> neg_s);
      OP_ROR: sc_res = (input1 >> shiftValue) | (input1 << neg_s);
      OP_MAX: sc_res = (input1 >= input2) ? input1 : input2;
      OP_MIN: sc_res = (input1 <= input2) ? input1 : input2;
      OP_ADD: begin
        sc_res   = sum_w[WIDTH-1:0];
        sc_carry = sum_w[WIDTH];
      end
      OP_SUB: begin
        sc_res   = dif_w[WIDTH-1:0];
        sc_carry = dif_w[WIDTH];
      end
      OP_DIV: sc_dz  = (input2 == '0);
      OP_NOR: sc_res = ~(input1 | input2);
      OP_OR:  sc_res = input1 | input2;
      default: sc_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    dz_d        = dz_q;
    ill_d       = ill_q;
    tag_d       = tag_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dsr_d       = dsr_q;
    dtag_d      = dtag_q;
    cnt_d       = cnt_q;

    trial     = {rem_q, quo_q[WIDTH-1]};
    trial_sub = trial - {1'b0, dsr_q};
    q_bit     = !trial_sub[WIDTH];
    rem_n     = q_bit ? trial_sub[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_n     = {quo_q[WIDTH-2:0], q_bit};

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fire) begin
          if (div_long) begin
            state_d = DIV_RUN;
            cnt_d   = CW'(WIDTH);
            rem_d   = '0;
            quo_d   = input1;
            dsr_d   = input2;
            dtag_d  = inTag;
          end else begin
            out_valid_d = 1'b1;
            result_d    = sc_res;
            carry_d     = sc_carry;
            zero_d      = (sc_res == '0);
            dz_d        = sc_dz;
            ill_d       = sc_ill;
            tag_d       = inTag;
          end
        end
      end
      DIV_RUN: begin
        rem_d = rem_n;
        quo_d = quo_n;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          result_d    = quo_n;
          carry_d     = 1'b0;
          zero_d      = (quo_n == '0);
          dz_d        = 1'b0;
          ill_d       = 1'b0;
          tag_d       = dtag_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      dz_q        <= 1'b0;
      ill_q       <= 1'b0;
      tag_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      dtag_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      dz_q        <= dz_d;
      ill_q       <= ill_d;
      tag_q       <= tag_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dsr_q       <= dsr_d;
      dtag_q      <= dtag_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign result        = result_q;
  assign carryFlag     = carry_q;
  assign zeroFlag      = zero_q;
  assign divZeroFlag   = dz_q;
  assign illegalOpFlag = ill_q;
  assign outTag        = tag_q;

endmodule

// File: tb/tb_alu_seq_pipe.sv
// tb_alu_seq_pipe: directed scenarios plus randomized traffic
// scored against an arithmetic reference model.
module tb_alu_seq_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [31:0] input1;
  logic [31:0] input2;
  logic [4:0]  shiftValue;
  logic [3:0]  inTag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carryFlag;
  logic        zeroFlag;
  logic        divZeroFlag;
  logic        illegalOpFlag;
  logic [3:0]  outTag;

  int checks = 0;
  int errors = 0;

  logic [40:0] obs;
  assign obs = {out_valid, outTag, result, carryFlag,
                zeroFlag, divZeroFlag, illegalOpFlag};

  alu_seq_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .input1(input1), .input2(input2),
    .shiftValue(shiftValue), .inTag(inTag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carryFlag(carryFlag),
    .zeroFlag(zeroFlag), .divZeroFlag(divZeroFlag),
    .illegalOpFlag(illegalOpFlag), .outTag(outTag)
  );

  always #5 clk = ~clk;

  // {result, carry, zero, divzero, illegal}
  function automatic logic [35:0] model(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [4:0] s);
    logic [31:0] r;
    logic [63:0] sum;
    logic c, dz, il;
    int sh;
    r = 0; c = 0; dz = 0; il = 0;
    sh = int'(s);
    case (op)
      4'd0: r = (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
      4'd1: r = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
      4'd2: r = (a >= b) ? a : b;
      4'd3: r = (a <= b) ? a : b;
      4'd4: begin
        sum = {32'd0, a} + {32'd0, b};
        r = sum[31:0];
        c = sum[32];
      end
      4'd5: begin r = a - b; c = (a < b); end
      4'd6: if (b == 0) dz = 1; else r = a / b;
      4'd7: r = ~(a | b);
      4'd8: r = a | b;
      default: il = 1;
    endcase
    return {r, c, (r == 32'd0), dz, il};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] s,
                       input logic [3:0] tag);
    in_valid = 1'b1;
    opcode = op;
    input1 = a;
    input2 = b;
    shiftValue = s;
    inTag = tag;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    step();
    checks++;
    if (obs !== 41'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got obs=%h rdy=%b want 0 rdy=1",
               obs, in_ready);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_div();
    int seen;
    out_ready = 1'b1;
    drive(4'd6, 32'd100, 32'd7, 5'd0, 4'd2);
    step();
    in_valid = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_div_ov: got %b want 0", out_valid);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_release: got rdy=%b ov=%b want 1 0",
               in_ready, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_no_result: got %0d valid cycles want 0", seen);
    end
  endtask

  task automatic test_pipeline();
    logic [3:0]  op [3];
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic [40:0] e [3];
    op = '{4'd4, 4'd5, 4'd0};
    a  = '{32'hFFFFFFFF, 32'd5, 32'h80000001};
    b  = '{32'd1, 32'd7, 32'd0};
    e[0] = {1'b1, 4'd3, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    e[1] = {1'b1, 4'd4, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b0};
    e[2] = {1'b1, 4'd5, 32'h80000001, 1'b0, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(op[i], a[i], b[i], 5'd0, 4'(i + 3));
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL pipe_rdy_%0d: got %b want 1", i, in_ready);
      end
      step();
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL pipe_%0d: got %h want %h", i, obs, e[i]);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pipe_drain: got %b want 0", out_valid);
    end
  endtask

  task automatic test_divide();
    int busy;
    logic [40:0] e;
    out_ready = 1'b1;
    drive(4'd6, 32'd1000, 32'd7, 5'd0, 4'd6);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL div_rdy: got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    busy = 0;
    for (int i = 0; i < 32; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) busy++;
      step();
    end
    checks++;
    if (busy != 0) begin
      errors++;
      $display("FAIL div_busy: got %0d bad cycles want 0", busy);
    end
    e = {1'b1, 4'd6, 32'd142, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL div_result: got %h want %h", obs, e);
    end
    drive(4'd6, 32'd5, 32'd0, 5'd0, 4'd7);
    step();
    in_valid = 1'b0;
    e = {1'b1, 4'd7, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL div_zero: got %h want %h", obs, e);
    end
    step();
  endtask

  task automatic test_backpressure();
    int bad;
    logic [40:0] held;
    logic [40:0] e;
    out_ready = 1'b0;
    drive(4'd8, 32'hF0, 32'h0F, 5'd0, 4'd1);
    step();
    drive(4'd7, 32'd0, 32'd0, 5'd0, 4'd2);
    held = {1'b1, 4'd1, 32'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== held) begin
      errors++;
      $display("FAIL bp_first: got %h want %h", obs, held);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready !== 1'b0 || obs !== held) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
    end
    out_ready = 1'b1;
    #1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    e = {1'b1, 4'd2, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL bp_handoff: got %h want %h", obs, e);
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_cmp_rot();
    logic [3:0]  op [4];
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [4:0]  s [4];
    logic [31:0] r [4];
    logic [40:0] e;
    op = '{4'd2, 4'd3, 4'd1, 4'd0};
    a  = '{32'd3, 32'd9, 32'h1, 32'h80000000};
    b  = '{32'hFFFFFFFF, 32'd9, 32'd0, 32'd0};
    s  = '{5'd0, 5'd0, 5'd1, 5'd31};
    r  = '{32'hFFFFFFFF, 32'd9, 32'h80000000, 32'h40000000};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(op[i], a[i], b[i], s[i], 4'(i + 8));
      step();
      e = {1'b1, 4'(i + 8), r[i], 1'b0, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL cmprot_%0d: got %h want %h", i, obs, e);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_illegal();
    logic [40:0] e;
    out_ready = 1'b1;
    drive(4'd12, $urandom, $urandom, 5'($urandom), 4'hA);
    step();
    in_valid = 1'b0;
    e = {1'b1, 4'hA, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL illegal: got %h want %h", obs, e);
    end
    step();
  endtask

  task automatic test_random();
    logic [39:0] q [$];
    logic [39:0] e;
    for (int i = 0; i < 800; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      opcode = 4'($urandom_range(0, 15));
      input1 = $urandom;
      case ($urandom_range(0, 3))
        0: input2 = 32'd0;
        1: input2 = $urandom_range(1, 15);
        default: input2 = $urandom;
      endcase
      shiftValue = 5'($urandom);
      inTag = 4'($urandom);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: got %h want none", obs);
        end else begin
          e = q.pop_front();
          if (obs[39:0] !== e) begin
            errors++;
            $display("FAIL rand_%0d: got %h want %h", i, obs[39:0], e);
          end
        end
      end
      if (in_valid && in_ready)
        q.push_back({inTag, model(opcode, input1, input2, shiftValue)});
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && q.size() > 0; i++) begin
      #1;
      if (out_valid) begin
        e = q.pop_front();
        checks++;
        if (obs[39:0] !== e) begin
          errors++;
          $display("FAIL rand_drain: got %h want %h", obs[39:0], e);
        end
      end
      step();
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rand_left: got %0d pending want 0", q.size());
    end
  endtask

  initial begin
    in_valid = 1'b0;
    out_ready = 1'b0;
    opcode = 4'd0;
    input1 = 32'd0;
    input2 = 32'd0;
    shiftValue = 5'd0;
    inTag = 4'd0;
    test_reset();
    test_reset_mid_div();
    test_pipeline();
    test_divide();
    test_backpressure();
    test_cmp_rot();
    test_illegal();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
